// File: rtl/prbs19_checker_if.sv
// Serial PRBS link bundle between the LFSR generator side and the checker.
// The generator side (master) drives the bit stream and the statistics clear.
// The checker side (slave) returns lock status, error pulses and counters.
interface prbs19_checker_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output din, din_valid, clr,
    input  locked, err_pulse, lock_lost, err_count, bit_count
  );

  modport slave (
    input  din, din_valid, clr,
    output locked, err_pulse, lock_lost, err_count, bit_count
  );
endinterface

// File: rtl/prbs19_checker.sv
// Self-synchronising checker for the 19-bit XOR LFSR stream (taps 18,5,1,0).
// HUNT loads 19 received bits into the history. CHECK then predicts every bit
// from that history and feeds the prediction (not the received bit) back in,
// so one corrupted bit costs exactly one error. Too many mismatches inside a
// monitoring window drop the checker back to HUNT.
module prbs19_checker #(
  parameter int CNT_W      = 16,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 8
) (
  input logic              clk,
  input logic              rst_n,
  prbs19_checker_if.slave  bus
);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam int               WIN_W     = $clog2(WIN_LEN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_LEN);
  localparam logic [WIN_W-1:0] ERR_LIMIT = WIN_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [4:0]       FILL_LAST = 5'd18;

  state_e           state_q, state_d;
  logic [18:0]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [WIN_W-1:0] win_bits_q, win_bits_d;
  logic [WIN_W-1:0] win_errs_q, win_errs_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked;

  logic             pred;
  logic             mismatch;
  logic [18:0]      hunt_shift;
  logic             fill_done;
  logic             hunt_nonzero;
  logic             count_bit;
  logic [WIN_W-1:0] win_bits_inc;
  logic [WIN_W-1:0] win_errs_inc;
  logic             thresh_hit;
  logic             win_end;

  // A bit that arrives together with clr is checked and shifted but not
  // counted, so it can neither advance the window nor trip the threshold.
  assign pred         = hist_q[0] ^ hist_q[1] ^ hist_q[5] ^ hist_q[18];
  assign mismatch     = bus.din ^ pred;
  assign hunt_shift   = {hist_q[17:0], bus.din};
  assign fill_done    = bus.din_valid && (state_q == HUNT) && (fill_q == FILL_LAST);
  assign hunt_nonzero = |hunt_shift;
  assign count_bit    = bus.din_valid && (state_q == CHECK) && !bus.clr;
  assign win_bits_inc = win_bits_q + WIN_W'(1);
  assign win_errs_inc = win_errs_q + WIN_W'(mismatch);
  assign thresh_hit   = count_bit && mismatch && (win_errs_inc == ERR_LIMIT);
  assign win_end      = (win_bits_inc == WIN_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // Next state: lock after a nonzero 19-bit fill, drop lock on the threshold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (fill_done && hunt_nonzero) state_d = CHECK;
      CHECK:   if (thresh_hit)                state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // Lock indication follows the state directly.
  always_comb begin
    locked = (state_q == CHECK);
  end

  // History, fill/window counters, statistics and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q      <= '0;
      fill_q      <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Per-bit update: fill in HUNT, predict/count/window in CHECK, clr last.
  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;

    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        hist_d = hunt_shift;
        fill_d = fill_done ? 5'd0 : fill_q + 5'd1;
      end else begin
        hist_d      = {hist_q[17:0], pred};
        err_pulse_d = mismatch;
        if (count_bit) begin
          if (bit_count_q != CNT_MAX) bit_count_d = bit_count_q + CNT_W'(1);
          if (mismatch && (err_count_q != CNT_MAX)) err_count_d = err_count_q + CNT_W'(1);
          if (thresh_hit) begin
            lock_lost_d = 1'b1;
            fill_d      = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
          end else if (win_end) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_inc;
            win_errs_d = win_errs_inc;
          end
        end
      end
    end

    if (bus.clr) begin
      err_count_d = '0;
      bit_count_d = '0;
      win_bits_d  = '0;
      win_errs_d  = '0;
    end
  end

  assign bus.locked    = locked;
  assign bus.err_pulse = err_pulse_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule
